// File: rtl/riscv_mul_pipe.sv
// Purpose : pipelined RV32M/RV64M multiplier (MUL/MULH/MULHSU/MULHU) carrying a writeback tag.
// Latency : STAGES cycles issue-to-result; one operation per cycle when not stalled.
// Backpr. : bubble-collapsing valid/ready; a full pipeline with out_ready_i=0 holds all state.
//
// Ports:
//   clk_i, rst_i (async, active-high), flush_i (kills everything in flight at the next edge)
//   in_valid_i/in_ready_o  + funct3_i, a_i, b_i, tag_i   : operation issue
//   out_valid_o/out_ready_i + result_o, tag_o            : selected product half and its tag
module riscv_mul_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       funct3_i,
  input  logic [XLEN-1:0]  a_i,
  input  logic [XLEN-1:0]  b_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int PW = 2 * XLEN;  // product width
  localparam int H  = XLEN / 2;  // split point of the rs2 operand

  // ---------------------------------------------------------------------------
  // Decode: operand signedness and which half of the product is returned.
  // 1xx falls into the default and behaves as MUL.
  // ---------------------------------------------------------------------------
  logic a_signed, b_signed, hi_sel;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    hi_sel   = 1'b0;
    case (funct3_i)
      3'b001: begin a_signed = 1'b1; b_signed = 1'b1; hi_sel = 1'b1; end
      3'b010: begin a_signed = 1'b1; b_signed = 1'b0; hi_sel = 1'b1; end
      3'b011: begin a_signed = 1'b0; b_signed = 1'b0; hi_sel = 1'b1; end
      default: begin a_signed = 1'b0; b_signed = 1'b0; hi_sel = 1'b0; end
    endcase
  end

  // Operands extended to XLEN+1 bits, so one signed multiply covers all modes.
  logic [XLEN:0] a_ext, b_ext;
  assign a_ext = {a_signed & a_i[XLEN-1], a_i};
  assign b_ext = {b_signed & b_i[XLEN-1], b_i};

  // Two partial products: rs1 x unsigned low half of rs2, and rs1 x signed
  // upper part of rs2 shifted into place. Everything is carried modulo 2^PW,
  // which is exactly the truncated signed product.
  logic [PW-1:0] a_w, b_lo_w, b_hi_w, pp_lo, pp_hi;
  assign a_w    = {{(XLEN-1){a_ext[XLEN]}}, a_ext};
  assign b_lo_w = {{(PW-H){1'b0}}, b_ext[H-1:0]};
  assign b_hi_w = {{(XLEN+H-1){b_ext[XLEN]}}, b_ext[XLEN:H]};
  assign pp_lo  = a_w * b_lo_w;
  assign pp_hi  = (a_w * b_hi_w) << H;

  // ---------------------------------------------------------------------------
  // Pipeline stages. Each stage holds valid, a partial sum plus a pending
  // addend, the hi/lo select and the tag. Stage 0 captures the two partial
  // products; stage 1 adds them; later stages just carry the sum. With a
  // single stage the add is done before the only register.
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0] vld_q, vld_in, en;
  logic [STAGES-1:0] hi_q, hi_d;
  logic [PW-1:0]     sum_q  [STAGES];
  logic [PW-1:0]     part_q [STAGES];
  logic [PW-1:0]     sum_d  [STAGES];
  logic [PW-1:0]     part_d [STAGES];
  logic [TAG_W-1:0]  tag_q  [STAGES];
  logic [TAG_W-1:0]  tag_d  [STAGES];

  // Stage k may load when it, or any stage after it, has a free slot, or the
  // output is being taken: the whole chain behind a bubble collapses forward.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      en[k] = out_ready_i;
      for (int j = k; j < STAGES; j++) begin
        if (!vld_q[j]) en[k] = 1'b1;
      end
    end
  end

  assign in_ready_o = en[0];

  always_comb begin
    vld_in[0] = in_valid_i;
    sum_d[0]  = (STAGES == 1) ? (pp_lo + pp_hi) : pp_lo;
    part_d[0] = (STAGES == 1) ? '0 : pp_hi;
    hi_d[0]   = hi_sel;
    tag_d[0]  = tag_i;
    for (int k = 1; k < STAGES; k++) begin
      vld_in[k] = vld_q[k-1];
      sum_d[k]  = sum_q[k-1] + part_q[k-1];
      part_d[k] = '0;
      hi_d[k]   = hi_q[k-1];
      tag_d[k]  = tag_q[k-1];
    end
  end

  // Valid bits: flush wins over any load; a loading stage whose source is
  // empty becomes a bubble.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
    end else if (flush_i) begin
      vld_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (en[k]) vld_q[k] <= vld_in[k];
      end
    end
  end

  // Payload only moves when a real operation moves, so a stalled output
  // stage keeps result_o/tag_o stable.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hi_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k]  <= '0;
        part_q[k] <= '0;
        tag_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (en[k] && vld_in[k]) begin
          sum_q[k]  <= sum_d[k];
          part_q[k] <= part_d[k];
          hi_q[k]   <= hi_d[k];
          tag_q[k]  <= tag_d[k];
        end
      end
    end
  end

  // The last stage's pending addend is always zero (it was folded in at
  // stage 1, or before the register for a single stage), so this add is
  // constant-folded away.
  logic [PW-1:0] prod;
  assign prod = sum_q[STAGES-1] + part_q[STAGES-1];

  assign out_valid_o = vld_q[STAGES-1];
  assign result_o    = hi_q[STAGES-1] ? prod[PW-1:XLEN] : prod[XLEN-1:0];
  assign tag_o       = tag_q[STAGES-1];

endmodule

// File: tb/tb_riscv_mul_pipe.sv
// Bench for riscv_mul_pipe: XLEN=32/STAGES=3 instance checked every cycle
// against a queue-based reference model, plus XLEN=64 instances with STAGES=1
// and STAGES=4 checked with hand-computed results and latencies.
module tb_riscv_mul_pipe;
  localparam int S  = 3;
  localparam int XL = 32;
  localparam int TW = 5;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          rst_i, flush_i, in_valid_i, out_ready_i;
  logic [2:0]    funct3_i;
  logic [XL-1:0] a_i, b_i;
  logic [TW-1:0] tag_in;
  logic          in_ready, out_valid;
  logic [XL-1:0] result;
  logic [TW-1:0] tag_out;

  riscv_mul_pipe #(.XLEN(XL), .STAGES(S), .TAG_W(TW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready),
    .funct3_i(funct3_i), .a_i(a_i), .b_i(b_i), .tag_i(tag_in),
    .out_valid_o(out_valid), .out_ready_i(out_ready_i),
    .result_o(result), .tag_o(tag_out)
  );

  // 64-bit instances sharing one stimulus
  logic          v64, flush64, ordy64;
  logic [2:0]    f64;
  logic [63:0]   a64, b64;
  logic [TW-1:0] t64;
  logic          rdy1, ov1, rdy4, ov4;
  logic [63:0]   res1, res4;
  logic [TW-1:0] tg1, tg4;

  riscv_mul_pipe #(.XLEN(64), .STAGES(1), .TAG_W(TW)) dut64s1 (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush64),
    .in_valid_i(v64), .in_ready_o(rdy1),
    .funct3_i(f64), .a_i(a64), .b_i(b64), .tag_i(t64),
    .out_valid_o(ov1), .out_ready_i(ordy64),
    .result_o(res1), .tag_o(tg1)
  );

  riscv_mul_pipe #(.XLEN(64), .STAGES(4), .TAG_W(TW)) dut64s4 (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush64),
    .in_valid_i(v64), .in_ready_o(rdy4),
    .funct3_i(f64), .a_i(a64), .b_i(b64), .tag_i(t64),
    .out_valid_o(ov4), .out_ready_i(ordy64),
    .result_o(res4), .tag_o(tg4)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Reference: plain 64-bit arithmetic on sign/zero-extended operands.
  function automatic logic [31:0] ref32(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] as, bs, p;
    as = {32'b0, a};
    bs = {32'b0, b};
    if (f == 3'b001 || f == 3'b010) as = {{32{a[31]}}, a};
    if (f == 3'b001) bs = {{32{b[31]}}, b};
    p = as * bs;
    return (f == 3'b001 || f == 3'b010 || f == 3'b011) ? p[63:32] : p[31:0];
  endfunction

  typedef struct packed {
    logic [31:0]   res;
    logic [TW-1:0] tag;
  } exp_t;
  exp_t q[$];

  // Stream bookkeeping: cycle in which each stream tag left the DUT.
  bit strm_on = 1'b0;
  int strm_cyc [20];

  // Compare process: every output-valid cycle must match the model head.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          fail_now($sformatf("unexpected_out tag=%0d result=%h", tag_out, result));
        end else begin
          chk("out_result", result, q[0].res);
          chk("out_tag", tag_out, q[0].tag);
          if (out_ready_i && !flush_i) begin
            if (strm_on && tag_out < 20) strm_cyc[tag_out] = cyc;
            void'(q.pop_front());
          end
        end
      end
      if (flush_i) q.delete();
      else if (in_valid_i && in_ready) q.push_back('{res: ref32(funct3_i, a_i, b_i), tag: tag_in});
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] t);
    in_valid_i = 1'b1;
    funct3_i   = f;
    a_i        = a;
    b_i        = b;
    tag_in     = t;
  endtask

  // Issue one op, measure cycles until out_valid, and check the result.
  task automatic issue_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [TW-1:0] t, input logic [31:0] exp_res);
    int n, lat;
    bit seen;
    set_op(f, a, b, t);
    n = cyc;
    tick();
    in_valid_i = 1'b0;
    seen = 1'b0;
    lat  = 0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk_i);
      if (out_valid) begin
        seen = 1'b1;
        lat  = cyc - n;
        chk("lat_result", result, exp_res);
        chk("lat_tag", tag_out, t);
      end
    end
    if (!seen) fail_now("latency_timeout");
    else chk("latency", lat, S);
    tick();
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 40 && (q.size() != 0 || out_valid); k++) tick();
    chk("drain_pending", q.size(), 0);
    chk("drain_out_valid", out_valid, 0);
  endtask

  task automatic run64(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                       input logic [TW-1:0] t, input logic [63:0] exp_res);
    int n;
    bit s1, s4;
    v64 = 1'b1; f64 = f; a64 = a; b64 = b; t64 = t;
    n = cyc;
    tick();
    v64 = 1'b0;
    s1 = 1'b0;
    s4 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      if (ov1 && !s1) begin
        s1 = 1'b1;
        chk("s1_latency", cyc - n, 1);
        chk("s1_result", res1, exp_res);
        chk("s1_tag", tg1, t);
      end
      if (ov4 && !s4) begin
        s4 = 1'b1;
        chk("s4_latency", cyc - n, 4);
        chk("s4_result", res4, exp_res);
        chk("s4_tag", tg4, t);
      end
    end
    if (!s1) fail_now("s1_timeout");
    if (!s4) fail_now("s4_timeout");
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int n;
    logic [TW-1:0] nt;
    rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    funct3_i = '0; a_i = '0; b_i = '0; tag_in = '0;
    v64 = 1'b0; flush64 = 1'b0; ordy64 = 1'b1; f64 = '0; a64 = '0; b64 = '0; t64 = '0;
    for (int i = 0; i < 20; i++) strm_cyc[i] = -1;

    // Model pins
    chk("model_mul",    ref32(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF), 64'h1);
    chk("model_mulh",   ref32(3'b001, 32'h80000000, 32'h80000000), 64'h40000000);
    chk("model_mulhu",  ref32(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF), 64'hFFFFFFFE);
    chk("model_mulhsu", ref32(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF), 64'hFFFFFFFF);
    chk("model_mulh2",  ref32(3'b001, 32'hFFFFFFFF, 32'h00000002), 64'hFFFFFFFF);
    chk("model_1xx",    ref32(3'b110, 32'h00000007, 32'h00000006), 64'h2A);

    // Reset state
    repeat (2) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_tag", tag_out, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst64_valid", {ov1, ov4}, 0);
    chk("rst64_ready", {rdy1, rdy4}, 2'b11);
    chk("rst64_result", res1 | res4, 0);
    rst_i = 1'b0;
    tick();
    chk("post_rst_in_ready", in_ready, 1);

    // Single MUL, latency
    issue_lat(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'h00000001);
    wait_drain();

    // High-half corners, back to back
    set_op(3'b001, 32'h80000000, 32'h80000000, 5'd10); tick();
    set_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11); tick();
    set_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12); tick();
    set_op(3'b001, 32'hFFFFFFFF, 32'h00000002, 5'd13); tick();
    in_valid_i = 1'b0;
    wait_drain();

    // Random back-to-back stream, tags 0..19
    strm_on = 1'b1;
    n = cyc;
    for (int i = 0; i < 20; i++) begin
      set_op(3'($urandom_range(0, 7)), $urandom, $urandom, 5'(i));
      tick();
    end
    in_valid_i = 1'b0;
    wait_drain();
    strm_on = 1'b0;
    for (int i = 0; i < 20; i++) chk($sformatf("stream_cycle_tag%0d", i), strm_cyc[i], n + S + i);

    // Backpressure
    out_ready_i = 1'b0;
    nt = 5'd20;
    acc = 0;
    set_op(3'($urandom_range(0, 3)), $urandom, $urandom, nt);
    for (int k = 0; k < 10; k++) begin
      if (!in_ready) break;
      acc++;
      tick();
      nt = nt + 5'd1;
      set_op(3'($urandom_range(0, 3)), $urandom, $urandom, nt);
    end
    chk("bp_accepts", acc, S);
    for (int k = 0; k < 5; k++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      tick();
    end
    out_ready_i = 1'b1;
    #1;
    chk("full_take_ready", in_ready, 1);
    tick();  // output taken and new input accepted together
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    #1;
    chk("occupancy_kept_ready", in_ready, 0);
    chk("occupancy_kept_valid", out_valid, 1);
    out_ready_i = 1'b1;
    wait_drain();

    // Flush with two ops in flight and a third presented
    set_op(3'b000, $urandom, $urandom, 5'd25); tick();
    set_op(3'b011, $urandom, $urandom, 5'd26); tick();
    set_op(3'b001, $urandom, $urandom, 5'd27);
    flush_i = 1'b1;
    tick();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    for (int k = 0; k < S + 3; k++) begin
      @(negedge clk_i);
      chk("flush_no_out", out_valid, 0);
    end
    tick();
    issue_lat(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9, 32'hFFFFFFFE);
    wait_drain();

    // Asynchronous reset in the middle of a cycle with ops in flight
    out_ready_i = 1'b0;
    set_op(3'b000, 32'd5, 32'd6, 5'd1); tick();
    set_op(3'b000, 32'd7, 32'd8, 5'd2); tick();
    in_valid_i = 1'b0;
    tick();
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_ready", in_ready, 1);
    q.delete();
    tick();
    rst_i       = 1'b0;
    out_ready_i = 1'b1;
    tick();
    issue_lat(3'b000, 32'd12345, 32'd678, 5'd7, 32'd8369910);
    wait_drain();

    // 64-bit instances
    run64(3'b000, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5'd3, 64'h1);
    run64(3'b011, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5'd4, 64'hFFFFFFFFFFFFFFFE);
    run64(3'b001, 64'h8000000000000000, 64'h8000000000000000, 5'd5, 64'h4000000000000000);
    run64(3'b010, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5'd6, 64'hFFFFFFFFFFFFFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
